ofs_fim_pcie_ss_tx_merge: RTL and testbench
===========================================

// Module: ofs_fim_pcie_ss_tx_merge
//
// PURPOSE
// Transmit-side counterpart of the RX dual-stream fork. Merges two AXI-S TLP
// streams into the single TX stream that feeds the PCIe SS:
//   - A: completions (CplD/Cpl)
//   - B: requests (MRd/MWr/Msg)
// Arbitration is packet-atomic: a packet is never interleaved with another.
// Uses in-band headers, one segment. Output is registered through a 2-entry skid buffer.
//
// PARAMETERS
// DATA_W      512  tdata width, in bits
// USER_W      10   tuser_vendor width; passed through unmodified
// CNT_W       32   width of the per-stream packet counters
//
// PORTS
// clk              in   1         clock
// rst_n            in   1         asynchronous, active-low reset
// a_tvalid         in   1         stream A beat valid
// a_tready         out  1         stream A beat accepted
// a_tdata          in   DATA_W    stream A data
// a_tkeep          in   DATA_W/8  stream A byte enables
// a_tlast          in   1         stream A end of packet
// a_tuser_vendor   in   USER_W    stream A sideband
// b_*              (six ports)    stream B; same names, directions and widths as a_*
// out_tvalid       out  1         merged stream beat valid
// out_tready       in   1         downstream ready
// out_tdata        out  DATA_W    merged data
// out_tkeep        out  DATA_W/8  merged byte enables
// out_tlast        out  1         merged end of packet
// out_tuser_vendor out  USER_W    merged sideband
// pkt_cnt_a        out  CNT_W     packets from A forwarded downstream
// pkt_cnt_b        out  CNT_W     packets from B forwarded downstream
//
// BEHAVIOUR
// - Reset (asynchronous assert, synchronous-to-clk release):
//   - out_tvalid=0, a_tready=0, b_tready=0, skid buffer empty
//   - state=IDLE, last_grant=B (A wins the first tie), pkt_cnt_a=pkt_cnt_b=0
//   - Reset mid-packet discards the partial packet; the bench must restart from a packet boundary.
// - Skid buffer: 2 entries, occupancy register occ in 0..2.
//   - space = (occ<2), derived only from registers; there is no combinational out_tready->in_tready path.
//   - A beat accepted at edge N is at the head, or visible at out_tvalid, at edge N+1 at the earliest (latency 1).
//   - Full throughput (1 beat/cycle) while out_tready=1.
//   - Simultaneous push and pop: occ is unchanged and order is preserved (FIFO).
// - State machine: IDLE, LOCK_A, LOCK_B.
//   - IDLE:
//     - Only A valid -> grant A. Only B valid -> grant B.
//     - Both valid -> grant the stream != last_grant.
//     - The grant is combinational and gated by space; x_tready = space && grant==x.
//   - Accepted beat in IDLE with tlast=0 -> LOCK_x.
//     - With tlast=1 (single-beat packet) -> stay in IDLE.
//     - In both cases last_grant <= x.
//   - LOCK_x: x_tready = space; the other tready is 0.
//     - The accepted beat with tlast=1 -> IDLE.
//     - Invalid cycles on x inside a packet keep the lock; the other stream waits.
// - tvalid/tdata are never dropped or altered. All fields of a beat move together.
//   - tkeep, tlast and tuser_vendor are passed through bit-exact.
// - Counters: pkt_cnt_x increments on the output handshake (out_tvalid && out_tready && out_tlast) of a beat sourced from x.
//   - Each skid entry carries a source tag bit.
//   - Counters wrap modulo 2^CNT_W with no saturation.
// - AXI-S rules:
//   - Once out_tvalid is asserted, the beat is held stable until accepted.
//   - Input valid may rise without waiting for ready.
//
// TESTING
// 1. A sends 3-beat packet, B idle, out_tready=1
//    -> out beats at cycles 1..3 after first accept; pkt_cnt_a=1, pkt_cnt_b=0.
// 2. Both valid from reset, each sending 2-beat packets continuously
//    -> output order A,B,A,B; no interleave; 1 beat/cycle.
// 3. A 4-beat packet with a_tvalid dropped on beat 2 for 5 cycles, B valid throughout
//    -> B held off (b_tready=0) until A's tlast is accepted.
// 4. out_tready=0 for 10 cycles during streaming
//    -> occ reaches 2; a_tready/b_tready=0; no beat lost or duplicated on resume.
// 5. Single-beat packets on both streams, 1000 each, random backpressure (1 in 16 low)
//    -> the scoreboard matches per-stream order; pkt_cnt_a=pkt_cnt_b=1000.
// 6. rst_n asserted mid-packet of B
//    -> out_tvalid=0 immediately; after release, A-first tie-break; counters=0.

Source files
------------

// File: rtl/ofs_fim_pcie_ss_tx_merge.sv
// Packet-atomic two-stream AXI-S TLP merge (A = completions, B = requests)
// feeding the PCIe SS TX port through a 2-entry registered skid buffer.
module ofs_fim_pcie_ss_tx_merge #(
  parameter int DATA_W = 512,
  parameter int USER_W = 10,
  parameter int CNT_W  = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                a_tvalid,
  output logic                a_tready,
  input  logic [DATA_W-1:0]   a_tdata,
  input  logic [DATA_W/8-1:0] a_tkeep,
  input  logic                a_tlast,
  input  logic [USER_W-1:0]   a_tuser_vendor,
  input  logic                b_tvalid,
  output logic                b_tready,
  input  logic [DATA_W-1:0]   b_tdata,
  input  logic [DATA_W/8-1:0] b_tkeep,
  input  logic                b_tlast,
  input  logic [USER_W-1:0]   b_tuser_vendor,
  output logic                out_tvalid,
  input  logic                out_tready,
  output logic [DATA_W-1:0]   out_tdata,
  output logic [DATA_W/8-1:0] out_tkeep,
  output logic                out_tlast,
  output logic [USER_W-1:0]   out_tuser_vendor,
  output logic [CNT_W-1:0]    pkt_cnt_a,
  output logic [CNT_W-1:0]    pkt_cnt_b
);
  localparam int KEEP_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B} state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;  // 0 = A, 1 = B
  logic             run_q;
  logic [1:0]       occ_q, occ_d;
  logic             wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_a_q, cnt_b_q;

  logic [DATA_W-1:0] data_q [2];
  logic [KEEP_W-1:0] keep_q [2];
  logic [USER_W-1:0] user_q [2];
  logic              last_q [2];
  logic              src_q  [2];

  logic space, grant_a, grant_b, push_a, push_b, push, pop;

  // run_q holds the inputs off while reset is asserted; space never looks at out_tready.
  assign space = run_q && (occ_q != 2'd2);

  always_comb begin
    grant_a      = 1'b0;
    grant_b      = 1'b0;
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (a_tvalid && (!b_tvalid || last_grant_q)) grant_a = 1'b1;
        else if (b_tvalid)                          grant_b = 1'b1;
      end
      LOCK_A:  grant_a = 1'b1;
      LOCK_B:  grant_b = 1'b1;
      default: ;
    endcase
    a_tready = space && grant_a;
    b_tready = space && grant_b;
    push_a   = a_tready && a_tvalid;
    push_b   = b_tready && b_tvalid;
    if (push_a) begin
      last_grant_d = 1'b0;
      state_d      = a_tlast ? IDLE : LOCK_A;
    end else if (push_b) begin
      last_grant_d = 1'b1;
      state_d      = b_tlast ? IDLE : LOCK_B;
    end
  end

  assign push = push_a || push_b;
  assign pop  = out_tvalid && out_tready;

  always_comb begin
    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      run_q        <= 1'b0;
      occ_q        <= 2'd0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      cnt_a_q      <= '0;
      cnt_b_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      run_q        <= 1'b1;
      occ_q        <= occ_d;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      if (pop && last_q[rd_ptr_q]) begin
        if (src_q[rd_ptr_q]) cnt_b_q <= cnt_b_q + CNT_W'(1);
        else                 cnt_a_q <= cnt_a_q + CNT_W'(1);
      end
    end
  end

  // Payload storage needs no reset: occ_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr_q] <= push_b ? b_tdata        : a_tdata;
      keep_q[wr_ptr_q] <= push_b ? b_tkeep        : a_tkeep;
      user_q[wr_ptr_q] <= push_b ? b_tuser_vendor : a_tuser_vendor;
      last_q[wr_ptr_q] <= push_b ? b_tlast        : a_tlast;
      src_q[wr_ptr_q]  <= push_b;
    end
  end

  assign out_tvalid       = (occ_q != 2'd0);
  assign out_tdata        = data_q[rd_ptr_q];
  assign out_tkeep        = keep_q[rd_ptr_q];
  assign out_tuser_vendor = user_q[rd_ptr_q];
  assign out_tlast        = last_q[rd_ptr_q];
  assign pkt_cnt_a        = cnt_a_q;
  assign pkt_cnt_b        = cnt_b_q;

endmodule

// File: tb/tb_ofs_fim_pcie_ss_tx_merge.sv
// Directed bench for ofs_fim_pcie_ss_tx_merge: per-stream queue model with
// ordering, atomicity, latency, backpressure and reset checks.
module tb_ofs_fim_pcie_ss_tx_merge;
  localparam int DATA_W = 512;
  localparam int USER_W = 10;
  localparam int CNT_W  = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              a_tvalid, a_tready, a_tlast;
  logic [DATA_W-1:0] a_tdata;
  logic [63:0]       a_tkeep;
  logic [USER_W-1:0] a_tuser_vendor;
  logic              b_tvalid, b_tready, b_tlast;
  logic [DATA_W-1:0] b_tdata;
  logic [63:0]       b_tkeep;
  logic [USER_W-1:0] b_tuser_vendor;
  logic              out_tvalid, out_tready, out_tlast;
  logic [DATA_W-1:0] out_tdata;
  logic [63:0]       out_tkeep;
  logic [USER_W-1:0] out_tuser_vendor;
  logic [CNT_W-1:0]  pkt_cnt_a, pkt_cnt_b;

  ofs_fim_pcie_ss_tx_merge #(.DATA_W(DATA_W), .USER_W(USER_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_tvalid(a_tvalid), .a_tready(a_tready), .a_tdata(a_tdata), .a_tkeep(a_tkeep),
    .a_tlast(a_tlast), .a_tuser_vendor(a_tuser_vendor),
    .b_tvalid(b_tvalid), .b_tready(b_tready), .b_tdata(b_tdata), .b_tkeep(b_tkeep),
    .b_tlast(b_tlast), .b_tuser_vendor(b_tuser_vendor),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata),
    .out_tkeep(out_tkeep), .out_tlast(out_tlast), .out_tuser_vendor(out_tuser_vendor),
    .pkt_cnt_a(pkt_cnt_a), .pkt_cnt_b(pkt_cnt_b)
  );

  typedef struct {
    logic [31:0] tag;
    logic        last;
    int          gap;
  } beat_t;

  beat_t aq[$], bq[$], ea[$], eb[$];
  int    out_cyc[$];
  logic  out_src[$];
  int    a_acc_cyc[$];

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   a_gap = 0, b_gap = 0;
  bit   a_loaded = 0, b_loaded = 0;
  bit   bp_rand = 0;
  logic rdy_cfg = 1'b1;
  bit   in_pkt = 0;
  logic pkt_src = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] make_tag(input logic src, input int pkt, input int beat);
    return {src, 23'(pkt), 8'(beat)};
  endfunction

  task automatic add_pkt(input logic src, input int pkt, input int nbeats,
                         input int gap_beat, input int gap_len);
    beat_t bt;
    for (int i = 0; i < nbeats; i++) begin
      bt.tag  = make_tag(src, pkt, i);
      bt.last = (i == nbeats - 1);
      bt.gap  = (i == gap_beat) ? gap_len : 0;
      if (src) begin bq.push_back(bt); eb.push_back(bt); end
      else     begin aq.push_back(bt); ea.push_back(bt); end
    end
  endtask

  task automatic drive();
    a_tvalid = 1'b0;
    if (aq.size() > 0) begin
      if (!a_loaded) begin a_gap = aq[0].gap; a_loaded = 1; end
      if (a_gap > 0) a_gap--;
      else begin
        a_tvalid = 1'b1; a_tdata = {16{aq[0].tag}}; a_tkeep = {2{aq[0].tag}};
        a_tlast = aq[0].last; a_tuser_vendor = aq[0].tag[9:0];
      end
    end
    b_tvalid = 1'b0;
    if (bq.size() > 0) begin
      if (!b_loaded) begin b_gap = bq[0].gap; b_loaded = 1; end
      if (b_gap > 0) b_gap--;
      else begin
        b_tvalid = 1'b1; b_tdata = {16{bq[0].tag}}; b_tkeep = {2{bq[0].tag}};
        b_tlast = bq[0].last; b_tuser_vendor = bq[0].tag[9:0];
      end
    end
    out_tready = bp_rand ? ($urandom_range(15) != 0) : rdy_cfg;
  endtask

  task automatic check_out(input logic [DATA_W-1:0] od, input logic [63:0] okp,
                           input logic ol, input logic [USER_W-1:0] ou);
    logic [31:0] tag;
    logic        src;
    int          avail;
    beat_t       e;
    tag = od[31:0];
    src = tag[31];
    chk("out_data", 64'(od === {16{tag}}), 64'(1));
    chk("out_keep", okp, {2{tag}});
    chk("out_user", 64'(ou), 64'(tag[9:0]));
    if (in_pkt) chk("atomic", 64'(src), 64'(pkt_src));
    avail = src ? eb.size() : ea.size();
    chk("expected_avail", 64'(avail > 0), 64'(1));
    if (avail > 0) begin
      e = src ? eb.pop_front() : ea.pop_front();
      chk("out_tag", 64'(tag), 64'(e.tag));
      chk("out_last", 64'(ol), 64'(e.last));
    end
    in_pkt  = !ol;
    pkt_src = src;
    out_cyc.push_back(cyc);
    out_src.push_back(src);
  endtask

  task automatic tick();
    logic a_hs, b_hs, o_hs, ol;
    logic [DATA_W-1:0] od;
    logic [63:0]       okp;
    logic [USER_W-1:0] ou;
    @(negedge clk);
    a_hs = a_tvalid && a_tready;
    b_hs = b_tvalid && b_tready;
    o_hs = out_tvalid && out_tready;
    od = out_tdata; okp = out_tkeep; ol = out_tlast; ou = out_tuser_vendor;
    @(posedge clk);
    #1;
    cyc++;
    if (a_hs) begin void'(aq.pop_front()); a_loaded = 0; a_acc_cyc.push_back(cyc); end
    if (b_hs) begin void'(bq.pop_front()); b_loaded = 0; end
    if (o_hs) check_out(od, okp, ol, ou);
    drive();
  endtask

  task automatic clear_logs();
    out_cyc.delete(); out_src.delete(); a_acc_cyc.delete();
  endtask

  task automatic clear_model();
    aq.delete(); bq.delete(); ea.delete(); eb.delete();
    a_loaded = 0; b_loaded = 0; a_gap = 0; b_gap = 0; in_pkt = 0;
    clear_logs();
  endtask

  task automatic release_reset();
    a_tvalid = 1'b0; b_tvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    clear_model();
    #10;
    release_reset();
  endtask

  task automatic drain(input string tag, input int limit);
    int n = 0;
    while ((aq.size() + bq.size() + ea.size() + eb.size()) > 0 && n < limit) begin
      tick();
      n++;
    end
    chk(tag, 64'(aq.size() + bq.size() + ea.size() + eb.size()), 64'(0));
  endtask

  initial begin
    int held;
    logic [DATA_W-1:0] stall_data;

    rst_n = 1'b0;
    a_tvalid = 1'b1; b_tvalid = 1'b1;
    a_tdata = '0; a_tkeep = '0; a_tlast = 1'b1; a_tuser_vendor = '0;
    b_tdata = '0; b_tkeep = '0; b_tlast = 1'b1; b_tuser_vendor = '0;
    out_tready = 1'b1;
    #23;
    chk("rst_out_tvalid", 64'(out_tvalid), 64'(0));
    chk("rst_a_tready", 64'(a_tready), 64'(0));
    chk("rst_b_tready", 64'(b_tready), 64'(0));
    chk("rst_cnt_a", 64'(pkt_cnt_a), 64'(0));
    chk("rst_cnt_b", 64'(pkt_cnt_b), 64'(0));
    release_reset();

    // 1: lone 3-beat A packet, latency 1, full rate
    add_pkt(1'b0, 1, 3, -1, 0);
    clear_logs();
    repeat (10) tick();
    chk("t1_accepts", 64'(a_acc_cyc.size()), 64'(3));
    chk("t1_outs", 64'(out_cyc.size()), 64'(3));
    if (out_cyc.size() == 3 && a_acc_cyc.size() > 0)
      for (int i = 0; i < 3; i++)
        chk("t1_out_cycle", 64'(out_cyc[i] - a_acc_cyc[0]), 64'(i + 1));
    chk("t1_cnt_a", 64'(pkt_cnt_a), 64'(1));
    chk("t1_cnt_b", 64'(pkt_cnt_b), 64'(0));

    // 2: both streams from reset, 2-beat packets
    do_reset();
    for (int p = 0; p < 4; p++) begin
      add_pkt(1'b0, 10 + p, 2, -1, 0);
      add_pkt(1'b1, 10 + p, 2, -1, 0);
    end
    clear_logs();
    drain("t2_drained", 200);
    chk("t2_outs", 64'(out_src.size()), 64'(16));
    if (out_src.size() == 16)
      for (int i = 0; i < 16; i++) begin
        chk("t2_order", 64'(out_src[i]), 64'((i / 2) % 2));
        chk("t2_rate", 64'(out_cyc[i] - out_cyc[0]), 64'(i));
      end
    chk("t2_cnt_a", 64'(pkt_cnt_a), 64'(4));
    chk("t2_cnt_b", 64'(pkt_cnt_b), 64'(4));

    // 3: A drops valid for 5 cycles before beat 2; B must stay held off
    add_pkt(1'b0, 20, 4, 1, 5);
    add_pkt(1'b1, 20, 2, -1, 0);
    clear_logs();
    held = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (aq.size() > 0 && aq.size() < 4) begin
        chk("t3_b_held", 64'(b_tready), 64'(0));
        held++;
      end
    end
    chk("t3_gap_seen", 64'(held >= 5), 64'(1));
    drain("t3_drained", 100);
    chk("t3_outs", 64'(out_src.size()), 64'(6));
    if (out_src.size() == 6)
      for (int i = 0; i < 6; i++) chk("t3_order", 64'(out_src[i]), 64'(i >= 4));

    // 4: 10-cycle downstream stall mid-stream
    for (int p = 0; p < 3; p++) begin
      add_pkt(1'b0, 30 + p, 3, -1, 0);
      add_pkt(1'b1, 30 + p, 3, -1, 0);
    end
    repeat (3) tick();
    rdy_cfg = 1'b0;
    tick();
    stall_data = out_tdata;
    repeat (9) tick();
    chk("t4_occ", 64'(dut.occ_q), 64'(2));
    chk("t4_a_tready", 64'(a_tready), 64'(0));
    chk("t4_b_tready", 64'(b_tready), 64'(0));
    chk("t4_out_tvalid", 64'(out_tvalid), 64'(1));
    chk("t4_hold", 64'(out_tdata === stall_data), 64'(1));
    rdy_cfg = 1'b1;
    drain("t4_drained", 200);

    // 5: 1000 single-beat packets per stream, random backpressure
    do_reset();
    for (int p = 0; p < 1000; p++) begin
      add_pkt(1'b0, p, 1, -1, 0);
      add_pkt(1'b1, p, 1, -1, 0);
    end
    bp_rand = 1;
    drain("t5_drained", 5000);
    bp_rand = 0;
    tick();
    chk("t5_cnt_a", 64'(pkt_cnt_a), 64'(1000));
    chk("t5_cnt_b", 64'(pkt_cnt_b), 64'(1000));

    // 6: reset in the middle of a B packet
    add_pkt(1'b1, 50, 4, -1, 0);
    for (int i = 0; i < 20 && bq.size() > 2; i++) tick();
    chk("t6_mid_pkt", 64'(bq.size()), 64'(2));
    #2 rst_n = 1'b0;
    #1;
    chk("t6_out_tvalid", 64'(out_tvalid), 64'(0));
    chk("t6_cnt_a", 64'(pkt_cnt_a), 64'(0));
    chk("t6_cnt_b", 64'(pkt_cnt_b), 64'(0));
    chk("t6_b_tready", 64'(b_tready), 64'(0));
    clear_model();
    #10;
    release_reset();
    add_pkt(1'b1, 60, 1, -1, 0);
    add_pkt(1'b0, 60, 1, -1, 0);
    drain("t6_drained", 50);
    chk("t6_outs", 64'(out_src.size()), 64'(2));
    if (out_src.size() == 2) chk("t6_first_a", 64'(out_src[0]), 64'(0));
    chk("t6_cnt_a_after", 64'(pkt_cnt_a), 64'(1));
    chk("t6_cnt_b_after", 64'(pkt_cnt_b), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
